// File: rtl/butterfly_r2_param_if.sv
// Streaming bus for the radix-2 butterfly: operand/twiddle request side,
// result response side, and the sticky overflow flag with its clear.
interface butterfly_r2_param_if #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int TAGW = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW-1:0]   a_i, a_q, b_i, b_q;
  logic signed [TW-1:0]   w_i, w_q;
  logic                   inv;
  logic                   scale;
  logic [TAGW-1:0]        tag_in;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [DW-1:0]   x_i, x_q, y_i, y_q;
  logic [TAGW-1:0]        tag_out;
  logic                   ovf;
  logic                   ovf_clr;

  modport master (
    output in_valid, a_i, a_q, b_i, b_q, w_i, w_q, inv, scale, tag_in,
    output out_ready, ovf_clr,
    input  in_ready, out_valid, x_i, x_q, y_i, y_q, tag_out, ovf
  );

  modport slave (
    input  in_valid, a_i, a_q, b_i, b_q, w_i, w_q, inv, scale, tag_in,
    input  out_ready, ovf_clr,
    output in_ready, out_valid, x_i, x_q, y_i, y_q, tag_out, ovf
  );
endinterface

// File: rtl/butterfly_r2_param.sv
// Three-stage radix-2 DIT butterfly: X = A + B*W', Y = A - B*W' with optional
// conjugate twiddle, rounding, halving and saturation; elastic valid/ready flow.
module butterfly_r2_lane #(
  parameter int DW = 16
)(
  input  logic [DW-1:0] a,
  input  logic [DW+1:0] bw,
  input  logic          sub,
  input  logic          scale,
  output logic [DW-1:0] res,
  output logic          clip
);
  localparam int RW = DW + 3;
  localparam logic signed [RW-1:0] ONE  = 1;
  localparam logic signed [RW-1:0] MAXV = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {4'b1111, {(DW-1){1'b0}}};

  logic signed [RW-1:0] sum, scl;

  always_comb begin
    sum  = sub ? RW'($signed(a)) - RW'($signed(bw))
               : RW'($signed(a)) + RW'($signed(bw));
    scl  = scale ? (sum + ONE) >>> 1 : sum;
    clip = 1'b0;
    res  = scl[DW-1:0];
    if (scl > MAXV) begin
      res  = MAXV[DW-1:0];
      clip = 1'b1;
    end else if (scl < MINV) begin
      res  = MINV[DW-1:0];
      clip = 1'b1;
    end
  end
endmodule

module butterfly_r2_param #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int TAGW = 8
)(
  input logic                 clk,
  input logic                 rst_n,
  butterfly_r2_param_if.slave bus
);
  localparam int STAGES    = 3;
  localparam int PW        = DW + TW + 1;
  localparam int SW        = DW + TW + 2;
  localparam int BW        = DW + 2;
  localparam int NUM_LANES = 4;
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (TW-2);

  typedef struct packed {
    logic signed [DW-1:0] a_i;
    logic signed [DW-1:0] a_q;
    logic                 scale;
    logic [TAGW-1:0]      tag;
  } ctx_t;

  logic              en;
  logic [STAGES:1]   vld_pipe;

  assign en            = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe[STAGES];

  // Twiddle widened by one bit so conj() of the most negative w_q is exact.
  logic signed [TW:0] wr, wi;
  assign wr = {bus.w_i[TW-1], bus.w_i};
  assign wi = bus.inv ? -{bus.w_q[TW-1], bus.w_q} : {bus.w_q[TW-1], bus.w_q};

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  ctx_t                 c1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
      c1   <= '0;
    end else if (en && bus.in_valid) begin
      p_rr <= PW'(bus.b_i) * PW'(wr);
      p_ii <= PW'(bus.b_q) * PW'(wi);
      p_ri <= PW'(bus.b_i) * PW'(wi);
      p_ir <= PW'(bus.b_q) * PW'(wr);
      c1   <= {bus.a_i, bus.a_q, bus.scale, bus.tag_in};
    end
  end

  logic signed [SW-1:0] re, im;
  logic signed [BW-1:0] bw_i_n, bw_q_n, bw_i, bw_q;
  ctx_t                 c2;

  always_comb begin
    re     = SW'(p_rr) - SW'(p_ii);
    im     = SW'(p_ri) + SW'(p_ir);
    bw_i_n = BW'((re + RND) >>> (TW-1));
    bw_q_n = BW'((im + RND) >>> (TW-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bw_i <= '0;
      bw_q <= '0;
      c2   <= '0;
    end else if (en && vld_pipe[1]) begin
      bw_i <= bw_i_n;
      bw_q <= bw_q_n;
      c2   <= c1;
    end
  end

  // Lanes 0..3 produce x_i, x_q, y_i, y_q.
  logic [NUM_LANES-1:0][DW-1:0] lane_a;
  logic [NUM_LANES-1:0][BW-1:0] lane_bw;
  logic [NUM_LANES-1:0]         lane_sub;
  logic [NUM_LANES-1:0][DW-1:0] lane_res;
  logic [NUM_LANES-1:0]         lane_clip;

  assign lane_a   = {c2.a_q, c2.a_i, c2.a_q, c2.a_i};
  assign lane_bw  = {bw_q, bw_i, bw_q, bw_i};
  assign lane_sub = 4'b1100;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    butterfly_r2_lane #(.DW(DW)) u_lane (
      .a     (lane_a[g]),
      .bw    (lane_bw[g]),
      .sub   (lane_sub[g]),
      .scale (c2.scale),
      .res   (lane_res[g]),
      .clip  (lane_clip[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      bus.x_i     <= '0;
      bus.x_q     <= '0;
      bus.y_i     <= '0;
      bus.y_q     <= '0;
      bus.tag_out <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
      if (vld_pipe[STAGES-1]) begin
        bus.x_i     <= lane_res[0];
        bus.x_q     <= lane_res[1];
        bus.y_i     <= lane_res[2];
        bus.y_q     <= lane_res[3];
        bus.tag_out <= c2.tag;
      end
    end
  end

  // A clip on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.ovf <= 1'b0;
    else if (en && vld_pipe[STAGES-1] && |lane_clip)
      bus.ovf <= 1'b1;
    else if (bus.ovf_clr)
      bus.ovf <= 1'b0;
  end
endmodule

// File: tb/tb_butterfly_r2_param.sv
// Self-checking bench: directed corner cases plus randomized streams against
// an arithmetic reference model and an in-order scoreboard.
module tb_butterfly_r2_param;
  localparam int DW = 16, TW = 16, TAGW = 8;
  localparam longint MAXV = (64'sd1 <<< (DW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (DW-1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  butterfly_r2_param_if #(.DW(DW), .TW(TW), .TAGW(TAGW)) bus();
  butterfly_r2_param #(.DW(DW), .TW(TW), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int ai, aq, bi, bq, wi, wq; bit inv, scale; int tag; } txn_t;
  typedef struct { longint xi, xq, yi, yq; int tag; bit clip; } res_t;

  int     n_chk = 0, n_fail = 0, cyc = 0, n_out = 0;
  res_t   expq[$];
  int     accq[$];
  txn_t   cur;
  bit     mon_en = 0, lat_on = 0, any_clip = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fin(longint a, longint bw, bit sc, inout bit c);
    longint s;
    s = a + bw;
    if (sc) s = (s + 1) >>> 1;
    if (s > MAXV) begin s = MAXV; c = 1; end
    else if (s < MINV) begin s = MINV; c = 1; end
    return s;
  endfunction

  function automatic res_t model(txn_t t);
    longint wqp, re, im, bwr, bwi;
    res_t   r;
    bit     c = 0;
    wqp = t.inv ? -longint'(t.wq) : longint'(t.wq);
    re  = longint'(t.bi) * t.wi - longint'(t.bq) * wqp;
    im  = longint'(t.bi) * wqp + longint'(t.bq) * t.wi;
    bwr = (re + (64'sd1 <<< (TW-2))) >>> (TW-1);
    bwi = (im + (64'sd1 <<< (TW-2))) >>> (TW-1);
    r.xi = fin(t.ai, bwr, t.scale, c);
    r.xq = fin(t.aq, bwi, t.scale, c);
    r.yi = fin(t.ai, -bwr, t.scale, c);
    r.yq = fin(t.aq, -bwi, t.scale, c);
    r.tag  = t.tag;
    r.clip = c;
    return r;
  endfunction

  function automatic txn_t mk(int ai, int aq, int bi, int bq, int wi, int wq,
                              bit inv, bit sc, int tag);
    txn_t t;
    t.ai = ai; t.aq = aq; t.bi = bi; t.bq = bq; t.wi = wi; t.wq = wq;
    t.inv = inv; t.scale = sc; t.tag = tag;
    return t;
  endfunction

  function automatic int rv(int w);
    if ($urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 2))
        0:       return -(1 << (w-1));
        1:       return (1 << (w-1)) - 1;
        default: return 0;
      endcase
    end
    return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w-1));
  endfunction

  function automatic txn_t rnd_txn(int tag);
    return mk(rv(DW), rv(DW), rv(DW), rv(DW), rv(TW), rv(TW),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag & 8'hff);
  endfunction

  task automatic drive(input txn_t t);
    cur = t;
    bus.a_i = t.ai[DW-1:0]; bus.a_q = t.aq[DW-1:0];
    bus.b_i = t.bi[DW-1:0]; bus.b_q = t.bq[DW-1:0];
    bus.w_i = t.wi[TW-1:0]; bus.w_q = t.wq[TW-1:0];
    bus.inv = t.inv; bus.scale = t.scale;
    bus.tag_in = t.tag[TAGW-1:0];
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard, stall-stability and ready-rule monitor, sampled on the falling edge.
  initial begin
    bit               stall_prev;
    logic signed [63:0] px [5];
    res_t             e;
    int               ac;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (stall_prev) begin
          chk("stall_vld", bus.out_valid, 1);
          chk("stall_xi", bus.x_i, px[0]);
          chk("stall_xq", bus.x_q, px[1]);
          chk("stall_yi", bus.y_i, px[2]);
          chk("stall_yq", bus.y_q, px[3]);
          chk("stall_tag", bus.tag_out, px[4]);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) chk("spurious_out", 1, 0);
          else begin
            e  = expq.pop_front();
            ac = accq.pop_front();
            chk("x_i", bus.x_i, e.xi);
            chk("x_q", bus.x_q, e.xq);
            chk("y_i", bus.y_i, e.yi);
            chk("y_q", bus.y_q, e.yq);
            chk("tag_out", bus.tag_out, e.tag);
            any_clip |= e.clip;
            if (lat_on) chk("latency", cyc - ac, 3);
            n_out++;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          expq.push_back(model(cur));
          accq.push_back(cyc);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        px[0] = bus.x_i; px[1] = bus.x_q; px[2] = bus.y_i; px[3] = bus.y_q;
        px[4] = 64'(bus.tag_out);
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic send(input txn_t t);
    bit a;
    a = 0;
    @(posedge clk); #1;
    drive(t);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      a = bus.in_ready;
      @(posedge clk); #1;
      if (a) break;
    end
    bus.in_valid = 1'b0;
    chk("send_accept", a, 1);
  endtask

  task automatic wait_out();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("wait_out", bus.out_valid, 1);
  endtask

  task automatic chk_out(input string nm, input int xi, input int xq,
                         input int yi, input int yq);
    chk({nm, "_xi"}, bus.x_i, xi);
    chk({nm, "_xq"}, bus.x_q, xq);
    chk({nm, "_yi"}, bus.y_i, yi);
    chk({nm, "_yq"}, bus.y_q, yq);
  endtask

  task automatic clr_ovf();
    @(posedge clk); #1; bus.ovf_clr = 1'b1;
    @(posedge clk); #1; bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.ovf, 0);
  endtask

  task automatic stream(input int n, input int pv, input int pr, input bit bp);
    txn_t t;
    bit   have, a;
    int   idx, n0;
    have = 0; idx = 0; n0 = n_out;
    for (int c = 0; c < 6*n + 100; c++) begin
      if (idx >= n && expq.size() == 0) break;
      if (!have && idx < n) begin t = rnd_txn(idx); have = 1; end
      bus.out_ready = bp ? !(c >= 3 && c < 8) : ($urandom_range(0, 99) < pr);
      if (have) drive(t);
      bus.in_valid = have && (bp || $urandom_range(0, 99) < pv);
      @(negedge clk);
      a = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (a) begin idx++; have = 0; end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_sent", idx, n);
    chk("stream_drain", expq.size(), 0);
    chk("stream_count", n_out - n0, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.out_ready = 0; bus.ovf_clr = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_x_i", bus.x_i, 0);
    chk("rst_y_q", bus.y_q, 0);
    chk("rst_tag", bus.tag_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    mon_en = 1; lat_on = 1;

    send(mk(1000, 0, 100, 0, -32768, 0, 0, 0, 5));
    wait_out();
    chk_out("basic", 900, 0, 1100, 0);
    chk("basic_tag", bus.tag_out, 5);
    chk("basic_ovf", bus.ovf, 0);

    send(mk(0, 0, 100, 0, 0, -32768, 1, 0, 6));
    wait_out();
    chk_out("inv1", 0, 100, 0, -100);
    send(mk(0, 0, 100, 0, 0, -32768, 0, 0, 7));
    wait_out();
    chk_out("inv0", 0, -100, 0, 100);

    send(mk(32767, 0, 32767, 0, -32768, 0, 0, 0, 8));
    wait_out();
    chk_out("sat", 0, 0, 32767, 0);
    chk("sat_ovf", bus.ovf, 1);
    clr_ovf();
    send(mk(32767, 0, 32767, 0, -32768, 0, 0, 1, 9));
    wait_out();
    chk_out("scale", 0, 0, 32767, 0);
    chk("scale_ovf", bus.ovf, 0);

    // Clip and clear on the same edge: the flag must end up set.
    @(posedge clk); #1; bus.ovf_clr = 1'b1;
    send(mk(-32768, 0, 32767, 0, 32767, 0, 0, 0, 10));
    wait_out();
    chk("ovf_set_wins", bus.ovf, 1);
    @(posedge clk); #1; bus.ovf_clr = 1'b0;

    lat_on = 0;
    stream(8, 100, 100, 1);

    // Reset with two transactions in flight and ovf set.
    @(posedge clk); #1;
    drive(mk(32767, 0, 32767, 0, -32768, 0, 0, 0, 8'hA1)); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(mk(100, 200, 300, 400, 16384, 0, 0, 0, 8'hA2));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_vld", bus.out_valid, 1);
    chk("pre_rst_ovf", bus.ovf, 1);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", bus.out_valid, 0);
    chk("midrst_y_i", bus.y_i, 0);
    chk("midrst_tag", bus.tag_out, 0);
    chk("midrst_ovf", bus.ovf, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    expq.delete();
    accq.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_ghost", bus.out_valid, 0);
    end
    lat_on = 1;
    send(mk(-5, 7, 1234, -4321, 23170, -23170, 0, 0, 8'h3C));
    wait_out();
    chk("post_rst_tag", bus.tag_out, 8'h3C);
    lat_on = 0;

    begin
      int pv[5] = '{90, 100, 70, 95, 100};
      int pr[5] = '{90, 100, 95, 70, 100};
      for (int b = 0; b < 5; b++) begin
        clr_ovf();
        any_clip = 0;
        stream(2000, pv[b], pr[b], 0);
        @(negedge clk);
        chk("ovf_block", bus.ovf, any_clip);
      end
    end
    clr_ovf();

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
